// File: rtl/dff_mon_pkg.sv
// Shared types and constants for the D flip-flop response monitor.
// Holds the FSM state encoding, default counter width and the warm-up clamp.
package dff_mon_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        CHECK,
        FAIL
    } state_t;

    function automatic int clamp_warmup(input int w);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dff_response_monitor_if.sv
// Observation and verdict bundle between a flop under test and its monitor.
// Optional first-error capture signals exist only with DFF_MON_FIRST_ERR_EN.
interface dff_response_monitor_if
    import dff_mon_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             en;
    logic             clr;
    logic             d_obs;
    logic             q_obs;
    logic             qbar_obs;
    logic             checking;
    logic             err_pulse;
    logic             fail;
    logic [CNT_W-1:0] checks;
    logic [CNT_W-1:0] errors;
`ifdef DFF_MON_FIRST_ERR_EN
    logic [CNT_W-1:0] first_err_at;
    logic             first_err_valid;

    modport master (
        output en, clr, d_obs, q_obs, qbar_obs,
        input  checking, err_pulse, fail, checks, errors, first_err_at, first_err_valid
    );
    modport slave (
        input  en, clr, d_obs, q_obs, qbar_obs,
        output checking, err_pulse, fail, checks, errors, first_err_at, first_err_valid
    );
`else
    modport master (
        output en, clr, d_obs, q_obs, qbar_obs,
        input  checking, err_pulse, fail, checks, errors
    );
    modport slave (
        input  en, clr, d_obs, q_obs, qbar_obs,
        output checking, err_pulse, fail, checks, errors
    );
`endif

endinterface

// File: rtl/dff_response_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; registered, holds at all-ones.
// Clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dff_response_monitor.sv
// Checks a single-bit DFF: Q against D of the previous edge, Qbar against ~Q; all outputs registered.
// Optional first-error index capture under DFF_MON_FIRST_ERR_EN. No backpressure.
module dff_response_monitor
    import dff_mon_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int WARMUP = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    dff_response_monitor_if.slave   mon
);

    localparam int WARM = clamp_warmup(WARMUP);
    localparam int WC_W = $clog2(WARM + 1);

    state_t            state, state_nxt;
    logic              exp_q, exp_nxt;
    logic [WC_W-1:0]   wcnt, wcnt_nxt;
    logic              chk_en;
    logic              mismatch;
    logic              err_pulse_q;
    logic              fail_q;
    logic [CNT_W-1:0]  checks_q;
    logic [CNT_W-1:0]  errors_q;

    assign mismatch = (mon.q_obs != exp_q) | (mon.qbar_obs != ~mon.q_obs);

    always_comb begin
        state_nxt = state;
        exp_nxt   = exp_q;
        wcnt_nxt  = wcnt;
        chk_en    = 1'b0;
        if (!mon.en) begin
            state_nxt = IDLE;
            exp_nxt   = 1'b0;
            wcnt_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    // The enabling edge itself is the first warm-up cycle.
                    exp_nxt   = mon.d_obs;
                    wcnt_nxt  = '0;
                    state_nxt = (WARM == 1) ? CHECK : dff_mon_pkg::WARMUP;
                end
                dff_mon_pkg::WARMUP: begin
                    exp_nxt  = mon.d_obs;
                    wcnt_nxt = wcnt + 1'b1;
                    if (int'(wcnt) + 2 >= WARM) begin
                        state_nxt = CHECK;
                    end
                end
                CHECK: begin
                    chk_en  = 1'b1;
                    exp_nxt = mon.d_obs;
                    if (mismatch) begin
                        state_nxt = FAIL;
                    end
                end
                FAIL: begin
                    chk_en  = 1'b1;
                    exp_nxt = mon.d_obs;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            exp_q       <= 1'b0;
            wcnt        <= '0;
            err_pulse_q <= 1'b0;
            fail_q      <= 1'b0;
        end else if (mon.clr) begin
            state       <= IDLE;
            exp_q       <= 1'b0;
            wcnt        <= '0;
            err_pulse_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            exp_q       <= exp_nxt;
            wcnt        <= wcnt_nxt;
            err_pulse_q <= chk_en & mismatch;
            if (chk_en & mismatch) begin
                fail_q <= 1'b1;
            end
        end
    end

    // errors only increments alongside checks, so errors <= checks even at saturation.
    sat_counter #(.W(CNT_W)) u_checks (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mon.clr),
        .inc   (chk_en),
        .cnt   (checks_q)
    );

    sat_counter #(.W(CNT_W)) u_errors (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mon.clr),
        .inc   (chk_en & mismatch),
        .cnt   (errors_q)
    );

    assign mon.checking  = (state == CHECK) || (state == FAIL);
    assign mon.err_pulse = err_pulse_q;
    assign mon.fail      = fail_q;
    assign mon.checks    = checks_q;
    assign mon.errors    = errors_q;

`ifdef DFF_MON_FIRST_ERR_EN
    logic [CNT_W-1:0] fe_at;
    logic             fe_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fe_at  <= '0;
            fe_vld <= 1'b0;
        end else if (mon.clr) begin
            fe_at  <= '0;
            fe_vld <= 1'b0;
        end else if (chk_en && mismatch && !fe_vld) begin
            fe_at  <= checks_q;
            fe_vld <= 1'b1;
        end
    end

    assign mon.first_err_at    = fe_at;
    assign mon.first_err_valid = fe_vld;
`endif

endmodule
